// File: rtl/seq_pattern_gen_pkg.sv
// Shared constants for the serial stimulus generator: LFSR seed/taps,
// default pattern and the mode encoding.
package seq_pkg;

  localparam logic [15:0] LFSR_SEED   = 16'hACE1;
  // Taps 15,13,12,10 for x^16+x^14+x^13+x^11+1 in shift-left form.
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [31:0] DEF_PATTERN = 32'h0000_B2D3;
  localparam int          DEF_PAT_LEN = 16;

  typedef enum logic {
    MODE_PATTERN = 1'b0,
    MODE_LFSR    = 1'b1
  } seq_mode_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Control inputs and serial/marker outputs of seq_pattern_gen.
interface seq_pattern_gen_if;
  // No backpressure: bit_strobe is a one-cycle qualifier; seq_bit, bit_idx and
  // frame_start are valid to sample on any cycle where bit_strobe is high.
  logic       enable;
  logic       mode;
  logic       seq_bit;
  logic       bit_strobe;
  logic [4:0] bit_idx;
  logic       frame_start;

  modport master (
    output enable, mode,
    input  seq_bit, bit_strobe, bit_idx, frame_start
  );

  modport slave (
    input  enable, mode,
    output seq_bit, bit_strobe, bit_idx, frame_start
  );
endinterface

// File: rtl/seq_pattern_gen_tick_divider.sv
// Clock-enable divider: one-cycle tick every DIV_COUNT enabled clk cycles.
module tick_divider #(
  parameter int DIV_COUNT = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == CW'(DIV_COUNT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (tick)        cnt_d = '0;
    else if (enable) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern source advancing one bit per divider tick, with frame markers.
// Optional LFSR mode is compiled in when SEQ_LFSR_EN is defined.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int          DIV_COUNT = 50_000_000,
  parameter int          PAT_LEN   = DEF_PAT_LEN,
  parameter logic [31:0] PATTERN   = DEF_PATTERN
) (
  input logic               clk,
  input logic               reset,
  seq_pattern_gen_if.slave  bus
);

  logic       tick;
  logic       seq_bit_q, seq_bit_d;
  logic       strobe_q;
  logic       frame_q;
  logic [4:0] idx_q, idx_d;
  logic       first_q;
  logic       new_frame;

  tick_divider #(.DIV_COUNT(DIV_COUNT)) u_div (
    .clk    (clk),
    .reset  (reset),
    .enable (bus.enable),
    .tick   (tick)
  );

`ifdef SEQ_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d, lfsr_src;
  seq_mode_e   mode_q, mode_in;
  logic        mode_switch;

  assign mode_in = seq_mode_e'(bus.mode);
`else
  logic unused_mode;
  assign unused_mode = bus.mode;
`endif

  always_comb begin
    new_frame = first_q || (idx_q == 5'(PAT_LEN - 1));
`ifdef SEQ_LFSR_EN
    mode_switch = (mode_in != mode_q);
    new_frame   = new_frame || mode_switch;
`endif
    idx_d     = new_frame ? 5'd0 : idx_q + 5'd1;
    seq_bit_d = PATTERN[5'(PAT_LEN - 1) - idx_d];
`ifdef SEQ_LFSR_EN
    // A mode switch restarts from the seed before the shift that yields the bit.
    lfsr_src = mode_switch ? LFSR_SEED : lfsr_q;
    lfsr_d   = lfsr_q;
    if (mode_in == MODE_LFSR) begin
      if (!mode_switch && lfsr_q == 16'h0) lfsr_d = LFSR_SEED;
      else                                 lfsr_d = lfsr_next(lfsr_src);
      seq_bit_d = lfsr_d[15];
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_bit_q <= 1'b0;
      strobe_q  <= 1'b0;
      frame_q   <= 1'b0;
      idx_q     <= 5'd0;
      first_q   <= 1'b1;
    end else begin
      strobe_q <= tick;
      frame_q  <= tick && new_frame;
      if (tick) begin
        seq_bit_q <= seq_bit_d;
        idx_q     <= idx_d;
        first_q   <= 1'b0;
      end
    end
  end

`ifdef SEQ_LFSR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
      mode_q <= MODE_PATTERN;
    end else if (tick) begin
      lfsr_q <= lfsr_d;
      mode_q <= mode_in;
    end
  end
`endif

  assign bus.seq_bit     = seq_bit_q;
  assign bus.bit_strobe  = strobe_q;
  assign bus.bit_idx     = idx_q;
  assign bus.frame_start = frame_q;

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Stimulus source directly upstream of the sequence detector: produces one serial bit per divided-clock tick from a fixed pattern (optionally an LFSR) and drives the detector's serial input. Replaces free-running divided-clock logic with a single-clock design: a tick strobe acts as clock enable, so detector and generator share `clk`. Also exports frame/strobe markers so benches and LEDs align with pattern boundaries.

## Interface
- `DIV_COUNT`, default 50_000_000: clk cycles per output bit; must be ≥ 2.
- `PAT_LEN`, default 16: pattern length in bits, 2..32.
- `PATTERN`, default 32'h0000_B2D3: pattern, bits [PAT_LEN-1:0] used, MSB sent first.
- `clk` in 1: system clock, all logic rising-edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `enable` in 1: run when high; when low, divider and sequence freeze.
- `mode` in 1: 0 = pattern, 1 = LFSR (ignored, treated as 0, without `SEQ_LFSR_EN`).
- `seq_bit` out 1: current serial bit, registered, held between strobes.
- `bit_strobe` out 1: one-cycle pulse on the cycle `seq_bit` takes a new value.
- `bit_idx` out 5: index of current bit within frame, 0..PAT_LEN-1.
- `frame_start` out 1: one-cycle pulse coincident with `bit_strobe` when `bit_idx` becomes 0.

## Operation
- Divider: counter 0..DIV_COUNT-1, increments each clk while `enable`; tick = counter at DIV_COUNT-1 and `enable`; counter wraps to 0 on tick.
- On tick, pattern mode: `seq_bit` ← PATTERN[PAT_LEN-1-next_idx]; `bit_idx` ← next_idx, where next_idx = 0 if a new frame starts, else `bit_idx`+1; at PAT_LEN-1 it wraps to 0.
- First tick after reset is a frame start: emits PATTERN[PAT_LEN-1], `bit_idx`=0, `frame_start`=1.
- On tick, LFSR mode: 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, shift left, feedback = s[15]^s[13]^s[12]^s[10] into s[0]; `seq_bit` ← s[15] of the new state. `bit_idx` counts modulo PAT_LEN as in pattern mode; `frame_start` at wrap.
- LFSR lock-up: if state is 0 on a tick, load seed 16'hACE1 instead of shifting.
- Mode switch: `mode` sampled every tick; if it differs from the registered mode, that tick starts a new frame (`bit_idx`=0, `frame_start`=1) and LFSR reloads seed before producing its bit.
- `enable` low: counter, `seq_bit`, `bit_idx`, LFSR, registered mode all hold; strobes 0. On re-enable, counting resumes from held count.
- Reset values: counter 0, `seq_bit` 0, `bit_strobe` 0, `bit_idx` 0, `frame_start` 0, LFSR 16'hACE1, mode 0, first-frame flag set.
- Reset mid-frame: immediate return to reset values; next tick is a frame start.

## Timing
- Latency reset-release to first `bit_strobe`: DIV_COUNT clk edges with `enable` high.
- Strobe period: exactly DIV_COUNT cycles while enabled.
- `seq_bit`, `bit_idx`, `bit_strobe`, `frame_start` all update on the same edge (tick edge); all are flops, no combinational paths from inputs.
- Downstream samples `seq_bit` when `bit_strobe` is high.

## Configuration
- `SEQ_LFSR_EN` defined: LFSR register, feedback, lock-up guard and mode register compiled in; `mode` honoured.
- Not defined: no LFSR logic; `mode` unconnected internally; output is pattern-only, frame-start logic unchanged.

## Structure
- Package `seq_pkg`: LFSR_SEED (16'hACE1), LFSR tap mask (16'hB400), default PATTERN and PAT_LEN constants, mode encodings (MODE_PATTERN=0, MODE_LFSR=1).
- One sub-module: `tick_divider` (params DIV_COUNT; ports clk, reset, enable, tick), reused by detector-side LED logic.
- Counter width = $clog2(DIV_COUNT); `bit_idx` fixed 5 bits.

## Test plan
- DIV_COUNT=4, PAT_LEN=16, PATTERN=16'hB2D3, mode 0: strobes every 4 cycles, first strobe 4 cycles after reset release; `seq_bit` stream 1,0,1,1,0,0,1,0,1,1,0,1,0,0,1,1, then repeats with `frame_start` on bits 0 and 16.
- Deassert `enable` for 10 cycles mid-frame at `bit_idx`=5: no strobes, outputs held; after re-enable next strobe gives `bit_idx`=6 after remaining count.
- Assert `reset` at `bit_idx`=9: outputs go to 0 immediately; after release first strobe has `bit_idx`=0, `seq_bit`=1, `frame_start`=1.
- With `SEQ_LFSR_EN`, mode 1 from reset: first 16 bits match software LFSR model from seed 16'hACE1; period 65535 ticks with no zero state.
- With `SEQ_LFSR_EN`, switch mode 0→1 at `bit_idx`=7: next strobe has `frame_start`=1, `bit_idx`=0, LFSR restarted from seed.
- Without `SEQ_LFSR_EN`, `mode`=1: output identical to pattern-mode scenario 1.
